alu_operand_stage: RTL and testbench

//  ID/EX pipeline stage directly upstream of the 32-bit ALU. Latches the decoded instruction and

---
 rtl/mips_pkg.sv | 28 ++
 rtl/operand_fwd_mux.sv | 36 +++
 rtl/alu_operand_stage.sv | 128 ++++++++++++
 tb/tb_alu_operand_stage.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared execute-front-end definitions: ALUfn bit positions, zero register index,
// and the result-forwarding port bundle with its match helper.
package mips_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  localparam int ALUFN_MATH  = 0;
  localparam int ALUFN_SHFT  = 1;
  localparam int ALUFN_BOOL0 = 2;
  localparam int ALUFN_BOOL1 = 3;
  localparam int ALUFN_SUB   = 4;
  localparam int ALUFN_W     = ALUFN_SUB + 1;

  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic                 en;
    logic [REG_IDX_W-1:0] idx;
    logic [XLEN-1:0]      data;
  } fwd_port_t;

  // r0 is hardwired to zero, so a write aimed at it never counts as a match.
  function automatic logic fwd_hit(input fwd_port_t p, input logic [REG_IDX_W-1:0] idx);
    return p.en && (p.idx == idx) && (idx != REG_ZERO);
  endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// Resolves one ALU source register: r0 -> 0, else EX/MEM over MEM/WB over regfile data.
// Purely combinational; forwarding ports are ignored unless ALU_OPERAND_FWD_EN is defined.
module operand_fwd_mux
  import mips_pkg::*;
#(
  parameter int N = XLEN
) (
  input  logic [REG_IDX_W-1:0] idx,
  input  logic [N-1:0]         reg_data,
  input  fwd_port_t            exm,
  input  fwd_port_t            wb,
  output logic [N-1:0]         operand
);

`ifdef ALU_OPERAND_FWD_EN
  always_comb begin
    operand = reg_data;
    if (idx == REG_ZERO)
      operand = '0;
    else if (fwd_hit(exm, idx))
      operand = exm.data[N-1:0];
    else if (fwd_hit(wb, idx))
      operand = wb.data[N-1:0];
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{exm, wb};

  always_comb begin
    operand = reg_data;
    if (idx == REG_ZERO)
      operand = '0;
  end
`endif

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX stage resolving ALU operands; 1-cycle latency, in_ready = ~out_valid | out_ready, held
// operands snoop MEM/WB writes while stalled. ALU_OPERAND_FWD_EN enables forwarding and snoop.
module alu_operand_stage
  import mips_pkg::*;
#(
  parameter int N   = XLEN,
  parameter int SHW = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [REG_IDX_W-1:0] rs_idx,
  input  logic [REG_IDX_W-1:0] rt_idx,
  input  logic [N-1:0]         rs_data,
  input  logic [N-1:0]         rt_data,
  input  logic [15:0]          imm,
  input  logic [SHW-1:0]       shamt,
  input  logic                 alu_src_imm,
  input  logic                 imm_zext,
  input  logic                 shamt_sel,
  input  logic [ALUFN_W-1:0]   alu_fn_in,
  input  logic [REG_IDX_W-1:0] dest_idx_in,
  input  logic                 exm_wr_en,
  input  logic [REG_IDX_W-1:0] exm_wr_idx,
  input  logic [N-1:0]         exm_wr_data,
  input  logic                 wb_wr_en,
  input  logic [REG_IDX_W-1:0] wb_wr_idx,
  input  logic [N-1:0]         wb_wr_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         alu_a,
  output logic [N-1:0]         alu_b,
  output logic [ALUFN_W-1:0]   alu_fn,
  output logic [REG_IDX_W-1:0] dest_idx
);

  fwd_port_t exm_port;
  fwd_port_t wb_port;
  logic [N-1:0] rs_res;
  logic [N-1:0] rt_res;
  logic [N-1:0] imm_ext;
  logic [N-1:0] a_next;
  logic [N-1:0] b_next;
  logic         accept;
  logic         snoop_a;
  logic         snoop_b;

  logic [REG_IDX_W-1:0] cap_rs_idx;
  logic [REG_IDX_W-1:0] cap_rt_idx;
  logic                 a_from_reg;
  logic                 b_from_reg;

  assign exm_port.en   = exm_wr_en;
  assign exm_port.idx  = exm_wr_idx;
  assign exm_port.data = XLEN'(exm_wr_data);
  assign wb_port.en    = wb_wr_en;
  assign wb_port.idx   = wb_wr_idx;
  assign wb_port.data  = XLEN'(wb_wr_data);

  operand_fwd_mux #(.N(N)) u_rs_mux (
    .idx      (rs_idx),
    .reg_data (rs_data),
    .exm      (exm_port),
    .wb       (wb_port),
    .operand  (rs_res)
  );

  operand_fwd_mux #(.N(N)) u_rt_mux (
    .idx      (rt_idx),
    .reg_data (rt_data),
    .exm      (exm_port),
    .wb       (wb_port),
    .operand  (rt_res)
  );

  assign imm_ext  = imm_zext ? {{(N-16){1'b0}}, imm} : {{(N-16){imm[15]}}, imm};
  assign a_next   = shamt_sel ? {{(N-SHW){1'b0}}, shamt} : rs_res;
  assign b_next   = alu_src_imm ? imm_ext : rt_res;
  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;

`ifdef ALU_OPERAND_FWD_EN
  // A stalled operand would otherwise go stale when its producer retires during the stall.
  assign snoop_a = a_from_reg & fwd_hit(wb_port, cap_rs_idx);
  assign snoop_b = b_from_reg & fwd_hit(wb_port, cap_rt_idx);
`else
  logic unused_cap;
  assign unused_cap = ^{cap_rs_idx, cap_rt_idx, a_from_reg, b_from_reg};
  assign snoop_a    = 1'b0;
  assign snoop_b    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_fn     <= '0;
      dest_idx   <= '0;
      cap_rs_idx <= '0;
      cap_rt_idx <= '0;
      a_from_reg <= 1'b0;
      b_from_reg <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      alu_a      <= a_next;
      alu_b      <= b_next;
      alu_fn     <= alu_fn_in;
      dest_idx   <= dest_idx_in;
      cap_rs_idx <= rs_idx;
      cap_rt_idx <= rt_idx;
      a_from_reg <= ~shamt_sel;
      b_from_reg <= ~alu_src_imm;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end else if (out_valid) begin
      if (snoop_a)
        alu_a <= wb_wr_data;
      if (snoop_b)
        alu_b <= wb_wr_data;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Randomized scoreboard bench for alu_operand_stage; expected operands come from a
// behavioural model of the stage's rules, checked by a monitor whenever out_valid is up.
module tb_alu_operand_stage;

  localparam int N   = 32;
  localparam int SHW = 5;
`ifdef ALU_OPERAND_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [4:0]     rs_idx, rt_idx;
  logic [N-1:0]   rs_data, rt_data;
  logic [15:0]    imm;
  logic [SHW-1:0] shamt;
  logic           alu_src_imm, imm_zext, shamt_sel;
  logic [4:0]     alu_fn_in, dest_idx_in;
  logic           exm_wr_en, wb_wr_en;
  logic [4:0]     exm_wr_idx, wb_wr_idx;
  logic [N-1:0]   exm_wr_data, wb_wr_data;
  logic           flush;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   alu_a, alu_b;
  logic [4:0]     alu_fn, dest_idx;

  always #5 clk = ~clk;

  alu_operand_stage #(.N(N), .SHW(SHW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rs_idx(rs_idx), .rt_idx(rt_idx), .rs_data(rs_data), .rt_data(rt_data),
    .imm(imm), .shamt(shamt), .alu_src_imm(alu_src_imm), .imm_zext(imm_zext),
    .shamt_sel(shamt_sel), .alu_fn_in(alu_fn_in), .dest_idx_in(dest_idx_in),
    .exm_wr_en(exm_wr_en), .exm_wr_idx(exm_wr_idx), .exm_wr_data(exm_wr_data),
    .wb_wr_en(wb_wr_en), .wb_wr_idx(wb_wr_idx), .wb_wr_data(wb_wr_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fn(alu_fn), .dest_idx(dest_idx)
  );

  typedef struct {
    logic [N-1:0] a, b;
    logic [4:0]   fn, dest, rs, rt;
    bit           a_reg, b_reg;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Value a source register holds as seen by the instruction being issued.
  function automatic logic [N-1:0] reg_value(input logic [4:0] idx, input logic [N-1:0] rdata);
    if (idx == 5'd0) return '0;
    if (FWD && exm_wr_en && exm_wr_idx == idx) return exm_wr_data;
    if (FWD && wb_wr_en && wb_wr_idx == idx) return wb_wr_data;
    return rdata;
  endfunction

  // Advances the model by one clock edge; the monitor has already retired a consumed entry.
  task automatic model_update();
    exp_t e;
    if (reset || flush) begin
      sb.delete();
    end else if (in_valid && sb.size() == 0) begin
      e.rs    = rs_idx;
      e.rt    = rt_idx;
      e.a_reg = !shamt_sel;
      e.b_reg = !alu_src_imm;
      e.a     = shamt_sel ? N'(shamt) : reg_value(rs_idx, rs_data);
      if (alu_src_imm)
        e.b = imm_zext ? N'(imm) : N'(signed'(imm));
      else
        e.b = reg_value(rt_idx, rt_data);
      e.fn   = alu_fn_in;
      e.dest = dest_idx_in;
      sb.push_back(e);
    end else if (FWD && sb.size() != 0 && wb_wr_en && wb_wr_idx != 5'd0) begin
      e = sb[0];
      if (e.a_reg && e.rs == wb_wr_idx) e.a = wb_wr_data;
      if (e.b_reg && e.rt == wb_wr_idx) e.b = wb_wr_data;
      sb[0] = e;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    in_valid = 0; flush = 0; exm_wr_en = 0; wb_wr_en = 0;
    shamt_sel = 0; alu_src_imm = 0; imm_zext = 0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("out_valid", N'(out_valid), N'(sb.size() != 0));
      check("in_ready", N'(in_ready), N'((sb.size() == 0) || out_ready));
      if (out_valid && sb.size() != 0) begin
        check("alu_a", alu_a, sb[0].a);
        check("alu_b", alu_b, sb[0].b);
        check("alu_fn", N'(alu_fn), N'(sb[0].fn));
        check("dest_idx", N'(dest_idx), N'(sb[0].dest));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    reset = 1; out_ready = 0; idle();
    rs_idx = 0; rt_idx = 0; rs_data = 0; rt_data = 0; imm = 0; shamt = 0;
    alu_fn_in = 0; dest_idx_in = 0; exm_wr_idx = 0; wb_wr_idx = 0;
    exm_wr_data = 0; wb_wr_data = 0;
    step(); step();
    check("rst_out_valid", N'(out_valid), '0);
    check("rst_alu_a", alu_a, '0);
    check("rst_alu_b", alu_b, '0);
    check("rst_alu_fn", N'(alu_fn), '0);
    check("rst_in_ready", N'(in_ready), N'(1));
    reset = 0; mon_en = 1;

    // EX/MEM wins over MEM/WB, then MEM/WB alone.
    out_ready = 1; in_valid = 1; rs_idx = 5; rs_data = 32'h33; rt_idx = 9; rt_data = 32'h9;
    exm_wr_en = 1; exm_wr_idx = 5; exm_wr_data = 32'h11;
    wb_wr_en = 1; wb_wr_idx = 5; wb_wr_data = 32'h22; alu_fn_in = 5'h03; dest_idx_in = 5'd2;
    step();
    check("t2_exm", alu_a, FWD ? 32'h11 : 32'h33);
    exm_wr_en = 0;
    step();
    check("t2_wb", alu_a, FWD ? 32'h22 : 32'h33);

    // r0 is never forwarded.
    rs_idx = 0; rs_data = 32'h7; exm_wr_en = 1; exm_wr_idx = 0; exm_wr_data = 32'hFFFF_FFFF;
    wb_wr_en = 0;
    step();
    check("t3_r0", alu_a, 32'h0);

    exm_wr_en = 0; alu_src_imm = 1; imm = 16'h8000; imm_zext = 0;
    step();
    check("t4_sext", alu_b, 32'hFFFF_8000);
    imm_zext = 1;
    step();
    check("t4_zext", alu_b, 32'h0000_8000);

    alu_src_imm = 0; imm_zext = 0; shamt_sel = 1; shamt = 5'd4;
    rt_idx = 3; rt_data = 32'h1; alu_fn_in = 5'b10110;
    step();
    check("t5_a", alu_a, 32'h4);
    check("t5_b", alu_b, 32'h1);
    check("t5_fn", N'(alu_fn), N'(5'b10110));

    idle(); step();

    // Stall with a late MEM/WB write to the held rt, then flush with a new instruction offered.
    out_ready = 0; in_valid = 1; rs_idx = 6; rs_data = 32'h55; rt_idx = 7; rt_data = 32'h1234;
    step();
    check("t6_hold1_in_ready", N'(in_ready), '0);
    step();
    wb_wr_en = 1; wb_wr_idx = 7; wb_wr_data = 32'hABCD;
    step();
    wb_wr_en = 0;
    check("t6_snoop_b", alu_b, FWD ? 32'hABCD : 32'h1234);
    check("t6_stable_a", alu_a, 32'h55);
    check("t6_hold3_in_ready", N'(in_ready), '0);
    flush = 1;
    step();
    check("t6_flush", N'(out_valid), '0);
    idle(); out_ready = 1; step();

    for (int c = 0; c < 3000; c++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 24) == 0);
      reset       = ($urandom_range(0, 99) == 0);
      rs_idx      = 5'($urandom_range(0, 7));
      rt_idx      = 5'($urandom_range(0, 7));
      rs_data     = $urandom;
      rt_data     = $urandom;
      imm         = 16'($urandom);
      shamt       = 5'($urandom);
      alu_src_imm = 1'($urandom_range(0, 1));
      imm_zext    = 1'($urandom_range(0, 1));
      shamt_sel   = ($urandom_range(0, 3) == 0);
      alu_fn_in   = 5'($urandom);
      dest_idx_in = 5'($urandom);
      exm_wr_en   = 1'($urandom_range(0, 1));
      exm_wr_idx  = 5'($urandom_range(0, 7));
      exm_wr_data = $urandom;
      wb_wr_en    = 1'($urandom_range(0, 1));
      wb_wr_idx   = 5'($urandom_range(0, 7));
      wb_wr_data  = $urandom;
      step();
    end

    reset = 0; idle(); out_ready = 1;
    repeat (3) step();
    check("drain_out_valid", N'(out_valid), '0);
    mon_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
